// File: rtl/tick_uart_tx.sv
// tick_uart_tx: byte-wide UART transmitter paced by an external divided-clock
// level. One frame = start bit, 8 data bits (LSB first), optional even parity
// bit, stop bit. Each bit lasts TICKS_PER_BIT rising edges of tick_in.
module tick_uart_tx #(
  parameter int TICKS_PER_BIT = 4,
  parameter int PARITY_EN     = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_out,
  output logic       busy,
  output logic       frame_done
);

  // Frame states. Encodings above ST_STOP are unreachable and fall back to idle.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Counter value on which the next tick closes the current bit period.
  localparam logic [7:0] TICK_LAST = 8'(TICKS_PER_BIT - 1);

  // State after the data bits: parity bit only when enabled.
  localparam logic [2:0] ST_AFTER_DATA = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;

  logic [2:0] state_q,      state_d;
  logic       tick_d_q;
  logic [7:0] cnt_q,        cnt_d;
  logic [2:0] bit_idx_q,    bit_idx_d;
  logic [7:0] shift_q,      shift_d;
  logic       par_q,        par_d;
  logic       tx_out_q,     tx_out_d;
  logic       frame_done_q, frame_done_d;

  logic       tick_pulse;
  logic       bit_end;
  logic       in_idle;

  // Rising-edge detect of the divider level and the end-of-bit strobe.
  always_comb begin
    tick_pulse = tick_in & ~tick_d_q;
    in_idle    = (state_q == ST_IDLE);
    bit_end    = tick_pulse && (cnt_q == TICK_LAST);
  end

  // Frame sequencing: acceptance, bit boundaries, data shifting, done pulse.
  always_comb begin
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    par_d        = par_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tx_valid) begin
          state_d   = ST_START;
          shift_d   = tx_data;
          // Even parity: the extra bit makes the total count of ones even.
          par_d     = ^tx_data;
          bit_idx_d = 3'd0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d   = {1'b0, shift_q[7:1]};
          // Index wraps back to 0 after the eighth bit.
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_AFTER_DATA;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          state_d      = ST_IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Tick counter: held at 0 while idle, cleared at every bit boundary so each
  // new bit starts counting from zero.
  always_comb begin
    cnt_d = cnt_q;
    if (in_idle) begin
      cnt_d = 8'd0;
    end else if (bit_end) begin
      cnt_d = 8'd0;
    end else if (tick_pulse) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Line level for the state being entered, so tx_out changes on the same
  // edge as the state and stays glitch-free as a flop output.
  always_comb begin
    case (state_d)
      ST_START:  tx_out_d = 1'b0;
      ST_DATA:   tx_out_d = shift_d[0];
      ST_PARITY: tx_out_d = par_d;
      default:   tx_out_d = 1'b1;
    endcase
  end

  // All state, with asynchronous reset to an idle, high line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      tick_d_q     <= 1'b0;
      cnt_q        <= 8'd0;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'd0;
      par_q        <= 1'b0;
      tx_out_q     <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_d_q     <= tick_in;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_q        <= par_d;
      tx_out_q     <= tx_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Handshake and status outputs.
  always_comb begin
    tx_ready   = in_idle;
    busy       = ~in_idle;
    tx_out     = tx_out_q;
    frame_done = frame_done_q;
  end

endmodule

// File: tb/tb_tick_uart_tx.sv
// Bench for tick_uart_tx: three instances (4 ticks/bit no parity, 4 ticks/bit
// even parity, 1 tick/bit no parity) fed by one divide-by-8 tick source.
// Expected line levels come from the frame bit list and a count of tick edges.
module tb_tick_uart_tx;

  logic       clk;
  logic       rst;
  logic       div_rst_n;
  logic [2:0] div_q;
  logic       tick_in;
  logic [2:0] v;
  logic [7:0] dv [3];
  wire  [2:0] rdy, txo, bsy, fd;

  int n_cmp;
  int n_bad;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Upstream divide-by-8: one rising edge of tick_in every 8 clk.
  always_ff @(posedge clk or negedge div_rst_n) begin
    if (!div_rst_n) div_q <= 3'd0;
    else            div_q <= div_q + 3'd1;
  end
  assign tick_in = div_q[2];

  tick_uart_tx #(.TICKS_PER_BIT(4), .PARITY_EN(0)) u_p0 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .tx_valid(v[0]), .tx_data(dv[0]),
    .tx_ready(rdy[0]), .tx_out(txo[0]), .busy(bsy[0]), .frame_done(fd[0]));
  tick_uart_tx #(.TICKS_PER_BIT(4), .PARITY_EN(1)) u_p1 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .tx_valid(v[1]), .tx_data(dv[1]),
    .tx_ready(rdy[1]), .tx_out(txo[1]), .busy(bsy[1]), .frame_done(fd[1]));
  tick_uart_tx #(.TICKS_PER_BIT(1), .PARITY_EN(0)) u_t1 (
    .clk(clk), .rst(rst), .tick_in(tick_in), .tx_valid(v[2]), .tx_data(dv[2]),
    .tx_ready(rdy[2]), .tx_out(txo[2]), .busy(bsy[2]), .frame_done(fd[2]));

  typedef struct {
    int          u;
    logic [7:0]  b;
    logic [10:0] frame;  // line bits in send order, bit 0 first
    int          nb;
  } vec_t;

  vec_t tbl [6];

  // Status vector layout: {tx_out, busy, tx_ready, frame_done}
  localparam logic [3:0] S_IDLE = 4'b1010;
  localparam logic [3:0] S_DONE = 4'b1011;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp, output bit ok);
    n_cmp++;
    ok = (act === exp);
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: {tx_out,busy,tx_ready,frame_done} got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] stat(input int u);
    return {txo[u], bsy[u], rdy[u], fd[u]};
  endfunction

  function automatic int tpb_of(input int u);
    return (u == 2) ? 1 : 4;
  endfunction

  // Frame bits from the byte: start 0, data LSB first, even parity, stop 1.
  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit par);
    logic p;
    p = ($countones(b) % 2) == 1;
    return par ? {1'b1, p, b, 1'b0} : {1'b0, 1'b1, b, 1'b0};
  endfunction

  task automatic idle_check(input int u, input int ncyc, input string nm);
    bit ok;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      chk(nm, stat(u), S_IDLE, ok);
    end
  endtask

  // Offer a byte, then follow the frame cycle by cycle. The line is expected
  // to show frame bit floor(n / ticks_per_bit), where n counts tick rising
  // edges seen since acceptance; after all bits it returns to idle with a
  // one-cycle done flag. Optional: keep valid high with a follow-on byte,
  // inject a stray valid at cycle inj, or reset inside bit abort_bit.
  task automatic send(input int u, input logic [7:0] b, input logic [10:0] frame, input int nb,
                      input bit hold, input logic [7:0] nxt, input int inj, input int abort_bit,
                      input string nm);
    int   k, n, tpb, lim;
    bit   ok;
    logic [3:0] exp;
    tpb = tpb_of(u);
    k = 0;
    while (rdy[u] !== 1'b1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk({nm, " ready"}, {3'b000, rdy[u]}, 4'b0001, ok);
    if (!ok) return;
    v[u]  = 1'b1;
    dv[u] = b;
    @(negedge clk);
    v[u] = hold;
    if (hold) dv[u] = nxt;
    n   = 0;
    lim = nb * tpb * 8 + 16;
    for (int c = 0; c < lim; c++) begin
      if (c == inj) begin
        v[u]  = 1'b1;
        dv[u] = 8'hFF;
      end else if (c == inj + 1) begin
        v[u] = 1'b0;
      end
      if (n >= nb * tpb) exp = S_DONE;
      else               exp = {frame[n / tpb], 3'b100};
      chk(nm, stat(u), exp, ok);
      if (!ok || n >= nb * tpb) begin
        if (!hold) v[u] = 1'b0;
        return;
      end
      if (n / tpb == abort_bit) begin
        v[u] = 1'b0;
        rst  = 1'b1;
        #1;
        chk({nm, " abort"}, stat(u), S_IDLE, ok);
        for (int r = 0; r < 4; r++) begin
          @(negedge clk);
          chk({nm, " in reset"}, stat(u), S_IDLE, ok);
        end
        rst = 1'b0;
        return;
      end
      // A rising edge of tick_in lands on the next clk edge when the
      // divider sits at 4 (level just went high).
      if (div_q == 3'd4) n++;
      @(negedge clk);
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s timeout: no frame end within %0d cycles", nm, lim);
  endtask

  initial begin
    int   k, u, nb, inj, gap;
    bit   ok, par;
    logic [7:0]  b;
    logic [10:0] fr;

    n_cmp     = 0;
    n_bad     = 0;
    rst       = 1'b1;
    div_rst_n = 1'b0;
    v         = 3'b000;
    for (int i = 0; i < 3; i++) dv[i] = 8'h00;

    tbl[0] = '{u: 0, b: 8'hA5, frame: 11'b0_1_10100101_0, nb: 10};
    tbl[1] = '{u: 1, b: 8'h07, frame: 11'b1_1_00000111_0, nb: 11};
    tbl[2] = '{u: 1, b: 8'h03, frame: 11'b1_0_00000011_0, nb: 11};
    tbl[3] = '{u: 2, b: 8'h81, frame: 11'b0_1_10000001_0, nb: 10};
    tbl[4] = '{u: 1, b: 8'hC3, frame: 11'b1_0_11000011_0, nb: 11};
    tbl[5] = '{u: 2, b: 8'hF0, frame: 11'b0_1_11110000_0, nb: 10};

    #25 div_rst_n = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) chk($sformatf("reset state u%0d", i), stat(i), S_IDLE, ok);

    // Release reset while tick_in is high: the spurious edge must do nothing.
    k = 0;
    while (tick_in !== 1'b1 && k < 16) begin
      @(negedge clk);
      k++;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) idle_check(i, 6, $sformatf("post-reset idle u%0d", i));

    // Directed frames from the table.
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].u, tbl[i].b, tbl[i].frame, tbl[i].nb, 1'b0, 8'h00, -1, -1,
           $sformatf("table[%0d] %02h", i, tbl[i].b));
      idle_check(tbl[i].u, 3, $sformatf("table[%0d] after", i));
    end

    // Valid held high across two frames: second starts right after done.
    send(0, 8'h55, mk_frame(8'h55, 1'b0), 10, 1'b1, 8'hAA, -1, -1, "b2b first 55");
    send(0, 8'hAA, mk_frame(8'hAA, 1'b0), 10, 1'b0, 8'h00, -1, -1, "b2b second AA");
    idle_check(0, 4, "b2b after");

    // Stray valid with FF in mid-DATA: ignored, nothing queued afterwards.
    send(0, 8'h96, mk_frame(8'h96, 1'b0), 10, 1'b0, 8'h00, 150, -1, "stray valid");
    idle_check(0, 40, "stray valid not queued");

    // Reset inside data bit 3 (frame bit 4), then a clean frame.
    send(0, 8'h5A, mk_frame(8'h5A, 1'b0), 10, 1'b0, 8'h00, -1, 4, "abort 5A");
    send(0, 8'h3C, mk_frame(8'h3C, 1'b0), 10, 1'b0, 8'h00, -1, -1, "after abort 3C");
    idle_check(0, 3, "after abort idle");

    // Random bytes across all three configurations.
    for (int i = 0; i < 14; i++) begin
      u   = int'($urandom_range(0, 2));
      b   = 8'($urandom());
      par = (u == 1);
      fr  = mk_frame(b, par);
      nb  = par ? 11 : 10;
      inj = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, nb * tpb_of(u) * 6)) : -1;
      send(u, b, fr, nb, 1'b0, 8'h00, inj, -1, $sformatf("rand[%0d] u%0d %02h", i, u, b));
      gap = int'($urandom_range(0, 4));
      repeat (gap) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
